// File: rtl/instruction_prefetch_buffer.sv
// -----------------------------------------------------------------------------
// instruction_prefetch_buffer
//
// Fetch-side queue between the instruction memory port and decode. Owns the
// fetch address, issues one word read per cycle while there is room, holds
// the request steady across multi-cycle misses and buffers up to DEPTH
// {pc, instruction} pairs for decode under a valid/ready handshake. A
// redirect from execute flushes the queue and restarts fetch at the target.
//
// Optional build macro: PREFETCH_STATS_EN adds the statFetched/statFlushed
// counters and ports. Without it the block behaves identically, minus the
// counters.
// -----------------------------------------------------------------------------
module instruction_prefetch_buffer #(
    parameter int unsigned DEPTH    = 4,            // power of two, >= 2
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    // redirect from execute
    input  logic        redirect,
    input  logic [31:0] redirectTarget,
    // instruction memory port
    output logic        memReadEnable,
    output logic [31:0] memAddress,
    input  logic [31:0] memData,
    input  logic        memSuccess,
    // decode handshake
    output logic        outValid,
    output logic [31:0] outInstruction,
    output logic [31:0] outProgramCounter,
    input  logic        consumerReady
`ifdef PREFETCH_STATS_EN
    ,
    output logic [31:0] statFetched,
    output logic [31:0] statFlushed
`endif
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);
    localparam logic [CNT_W-1:0] FULL_COUNT = CNT_W'(DEPTH);

    // Fetch addresses are always word aligned, so only bits [31:2] are kept.
    // Incrementing the word address wraps 32'hFFFFFFFC to 0 for free.
    logic [29:0]      fetch_pc_q,  fetch_pc_d;
    logic [PTR_W-1:0] read_ptr_q,  read_ptr_d;
    logic [PTR_W-1:0] write_ptr_q, write_ptr_d;
    logic [CNT_W-1:0] count_q,     count_d;

    // Entry storage: word-aligned pc and the fetched instruction.
    logic [29:0] pc_mem_q    [DEPTH];
    logic [31:0] instr_mem_q [DEPTH];

    logic queue_full;
    logic queue_empty;
    logic push;
    logic pop;

    // Byte-offset bits of the redirect target carry no meaning here.
    logic unused_target_bits;
    assign unused_target_bits = ^redirectTarget[1:0];

    // -------------------------------------------------------------------------
    // Memory request and decode-side outputs
    // -------------------------------------------------------------------------
    assign queue_full  = (count_q == FULL_COUNT);
    assign queue_empty = (count_q == '0);

    // A full queue never requests, even if decode pops in the same cycle;
    // this keeps consumerReady out of the memory request path.
    assign memReadEnable = ~queue_full & ~redirect & ~rst;
    assign memAddress    = {fetch_pc_q, 2'b00};

    assign push = memReadEnable & memSuccess;

    assign outValid = ~queue_empty & ~redirect;
    assign pop      = outValid & consumerReady;

    // Head entry presented to decode; zeroes when nothing is buffered.
    always_comb begin
        // NOTE: every output of a combinational block gets a default first so
        // no path can leave it unassigned and infer a latch.
        outInstruction    = '0;
        outProgramCounter = '0;
        if (!queue_empty) begin
            outInstruction    = instr_mem_q[read_ptr_q];
            outProgramCounter = {pc_mem_q[read_ptr_q], 2'b00};
        end
    end

    // -------------------------------------------------------------------------
    // Next-state logic for fetch address, pointers and occupancy
    // -------------------------------------------------------------------------

    // Redirect flushes and retargets; otherwise apply push/pop independently.
    always_comb begin
        fetch_pc_d  = fetch_pc_q;
        read_ptr_d  = read_ptr_q;
        write_ptr_d = write_ptr_q;
        count_d     = count_q;

        if (redirect) begin
            // Any outstanding miss is abandoned; the first request at the
            // target goes out next cycle.
            fetch_pc_d  = redirectTarget[31:2];
            read_ptr_d  = '0;
            write_ptr_d = '0;
            count_d     = '0;
        end else begin
            if (push) begin
                write_ptr_d = write_ptr_q + PTR_W'(1);
                fetch_pc_d  = fetch_pc_q + 30'd1;
            end
            if (pop) begin
                read_ptr_d = read_ptr_q + PTR_W'(1);
            end
            case ({push, pop})
                2'b10:   count_d = count_q + CNT_W'(1);
                2'b01:   count_d = count_q - CNT_W'(1);
                default: count_d = count_q;
            endcase
        end
    end

    // -------------------------------------------------------------------------
    // State registers
    // -------------------------------------------------------------------------

    // Control state: synchronous reset, which also overrides a redirect.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples the pre-edge values, independent of block order.
        if (rst) begin
            fetch_pc_q  <= RESET_PC[31:2];
            read_ptr_q  <= '0;
            write_ptr_q <= '0;
            count_q     <= '0;
        end else begin
            fetch_pc_q  <= fetch_pc_d;
            read_ptr_q  <= read_ptr_d;
            write_ptr_q <= write_ptr_d;
            count_q     <= count_d;
        end
    end

    // Entry storage: written on push only.
    always_ff @(posedge clk) begin
        // NOTE: the entry arrays are deliberately not reset; count_q gates
        // every read, so stale contents are never observed and the storage
        // can map onto plain RAM/flops without a reset network.
        if (push) begin
            pc_mem_q[write_ptr_q]    <= fetch_pc_q;
            instr_mem_q[write_ptr_q] <= memData;
        end
    end

`ifdef PREFETCH_STATS_EN
    // -------------------------------------------------------------------------
    // Fetch statistics
    // -------------------------------------------------------------------------
    logic [31:0] stat_fetched_q, stat_fetched_d;
    logic [31:0] stat_flushed_q, stat_flushed_d;

    // Count pushed words and the entries thrown away by each redirect.
    always_comb begin
        stat_fetched_d = stat_fetched_q + (push ? 32'd1 : 32'd0);
        stat_flushed_d = stat_flushed_q;
        if (redirect) begin
            stat_flushed_d = stat_flushed_q + 32'(count_q);
        end
    end

    // Statistics registers, cleared by reset and free-running modulo 2^32.
    always_ff @(posedge clk) begin
        if (rst) begin
            stat_fetched_q <= '0;
            stat_flushed_q <= '0;
        end else begin
            stat_fetched_q <= stat_fetched_d;
            stat_flushed_q <= stat_flushed_d;
        end
    end

    assign statFetched = stat_fetched_q;
    assign statFlushed = stat_flushed_q;
`endif

endmodule
